// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains a job of `len` words from a synchronous FIFO and presents them on a
// valid/ready output stream. Reads are credit-limited so that the words held in
// the 2-entry skid buffer plus the word still in flight never exceed two. The
// word popped from the buffer in the current cycle counts as free space, so a
// full-rate FIFO with a ready sink sustains one word per cycle.
//
// Ports
//   clk           : clock, all state on the rising edge
//   rst           : synchronous active-high reset
//   start         : request a drain job (accepted only when idle)
//   len           : number of words in the job, sampled with an accepted start
//   busy          : job in progress (RUN state)
//   done          : one-cycle pulse when the job completes
//   fifo_empty    : FIFO empty flag
//   fifo_rd_en    : FIFO read strobe
//   fifo_rd_data  : FIFO read data, valid the cycle after the strobe
//   fifo_rd_error : FIFO underflow flag, qualifies the strobe in the same cycle
//   m_valid       : output word available
//   m_ready       : downstream accepts the word
//   m_data        : output word (zero while m_valid is low)
//   err           : sticky read-error flag, cleared by reset or accepted start
//   rd_count      : words delivered on m_* in the current job
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    input  logic                 fifo_rd_error,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] rd_count
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Job bookkeeping
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic                 err_q, err_d;

    // A successful strobe last cycle: its data is on fifo_rd_data now
    logic                 inflight_q, inflight_d;

    // 2-entry skid buffer, circular with one-bit pointers
    logic [WIDTH-1:0]     buf_q [2];
    logic [WIDTH-1:0]     buf_d [2];
    logic                 buf_wr_ptr_q, buf_wr_ptr_d;
    logic                 buf_rd_ptr_q, buf_rd_ptr_d;
    logic [1:0]           buf_cnt_q, buf_cnt_d;

    // Internal strobes
    logic                 start_acc;
    logic                 rd_en;
    logic                 rd_ok;
    logic                 capture;
    logic                 pop;
    logic                 job_done;
    logic [1:0]           occupancy;

    // -------------------------------------------------------------------------
    // Control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        start_acc = (state_q == StIdle) && start;
        pop       = (buf_cnt_q != 2'd0) && m_ready;
        capture   = inflight_q;
        // buffered + in-flight never exceeds 2, so the sum cannot wrap in 2 bits;
        // pop implies buf_cnt_q >= 1, so the subtraction cannot underflow.
        occupancy = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_en     = (state_q == StRun) && !fifo_empty && (issued_q < len_q) &&
                    (occupancy < 2'd2);
        rd_ok     = rd_en && !fifo_rd_error;
        job_done  = (issued_q == len_q) && (rd_count_q == len_q);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // An empty job has nothing to read; report completion directly.
                    state_d = (len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (job_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy       = (state_q == StRun);
        done       = (state_q == StDone);
        fifo_rd_en = rd_en;
        m_valid    = (buf_cnt_q != 2'd0);
        m_data     = m_valid ? buf_q[buf_rd_ptr_q] : '0;
        err        = err_q;
        rd_count   = rd_count_q;
    end

    // -------------------------------------------------------------------------
    // Datapath next state
    // -------------------------------------------------------------------------
    always_comb begin
        len_d        = len_q;
        issued_d     = issued_q;
        rd_count_d   = rd_count_q;
        err_d        = err_q;
        inflight_d   = rd_ok;
        buf_d[0]     = buf_q[0];
        buf_d[1]     = buf_q[1];
        buf_wr_ptr_d = buf_wr_ptr_q;
        buf_rd_ptr_d = buf_rd_ptr_q;
        buf_cnt_d    = buf_cnt_q;

        if (start_acc) begin
            len_d      = len;
            issued_d   = '0;
            rd_count_d = '0;
            err_d      = 1'b0;
        end else begin
            // A read flagged as underflow carries no data and is retried later.
            if (rd_ok) begin
                issued_d = issued_q + 1'b1;
            end
            if (rd_en && fifo_rd_error) begin
                err_d = 1'b1;
            end
            if (pop) begin
                rd_count_d = rd_count_q + 1'b1;
            end
        end

        if (capture) begin
            buf_d[buf_wr_ptr_q] = fifo_rd_data;
            buf_wr_ptr_d        = ~buf_wr_ptr_q;
        end
        if (pop) begin
            buf_rd_ptr_d = ~buf_rd_ptr_q;
        end

        unique case ({capture, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers. Clearing inflight_q on reset drops a read that was
    // strobed in the reset cycle, so its data never reaches the buffer.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= '0;
            issued_q     <= '0;
            rd_count_q   <= '0;
            err_q        <= 1'b0;
            inflight_q   <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            buf_wr_ptr_q <= 1'b0;
            buf_rd_ptr_q <= 1'b0;
            buf_cnt_q    <= 2'd0;
        end else begin
            len_q        <= len_d;
            issued_q     <= issued_d;
            rd_count_q   <= rd_count_d;
            err_q        <= err_d;
            inflight_q   <= inflight_d;
            buf_q[0]     <= buf_d[0];
            buf_q[1]     <= buf_d[1];
            buf_wr_ptr_q <= buf_wr_ptr_d;
            buf_rd_ptr_q <= buf_rd_ptr_d;
            buf_cnt_q    <= buf_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Bench for fifo_stream_reader. A queue-based FIFO model feeds the DUT; every
// word successfully read from it is appended to an expected-delivery queue and
// must appear on m_* in the same order. Directed sequences cover the drain,
// backpressure, zero-length, starved, reset and ignored-start cases; a table
// of randomized jobs covers mixed ready/starvation/error patterns.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CNT_WIDTH-1:0] len;
    logic                 busy;
    logic                 done;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [WIDTH-1:0]     fifo_rd_data;
    logic                 fifo_rd_error;
    logic                 m_valid;
    logic                 m_ready;
    logic [WIDTH-1:0]     m_data;
    logic                 err;
    logic [CNT_WIDTH-1:0] rd_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_error (fifo_rd_error),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .err           (err),
        .rd_count      (rd_count)
    );

    typedef struct {
        int len;
        int preload;
        int push_gap;
        int ready_pct;
        int err_pct;
        int exp_words;
        int exp_done;
    } vec_t;

    // Model state
    logic [7:0] fifo_q [$];
    logic [7:0] src_q  [$];
    logic [7:0] exp_q  [$];
    logic [7:0] got_q  [$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   delivered   = 0;
    int   reads_ok    = 0;
    int   strobes     = 0;
    int   done_cnt    = 0;
    int   gap_cnt     = 0;
    int   push_gap    = 0;
    int   ready_pct   = 100;
    int   err_pct     = 0;
    int   job_len     = 0;
    bit   err_exp     = 1'b0;
    bit   job_active  = 1'b0;
    bit   prev_stall  = 1'b0;
    logic [7:0] prev_data = '0;

    bit                   start_drv  = 1'b0;
    bit                   accept_drv = 1'b0;
    bit                   rst_drv    = 1'b0;
    logic [CNT_WIDTH-1:0] len_drv    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check, then model the edge.
    task automatic tick();
        bit rd_now;
        bit rd_err;
        @(negedge clk);
        rst           = rst_drv;
        start         = start_drv;
        len           = len_drv;
        m_ready       = ($urandom_range(0, 99) < ready_pct);
        fifo_rd_error = ($urandom_range(0, 99) < err_pct);
        if (src_q.size() != 0) begin
            if (gap_cnt == 0) begin
                fifo_q.push_back(src_q.pop_front());
                gap_cnt = push_gap;
            end else begin
                gap_cnt--;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
        chk("rd_count", 32'(rd_count), 32'(delivered));
        chk("err", 32'(err), 32'(err_exp));
        if (fifo_rd_en) begin
            chk("rd_en_while_empty", 32'(fifo_empty), 0);
            chk("rd_en_while_not_busy", 32'(busy), 1);
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(m_valid), 0);
            end else begin
                chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            got_q.push_back(m_data);
            delivered++;
        end
        if (done) begin
            done_cnt++;
            chk("done_after_all_words", 32'(delivered), 32'(job_len));
            chk("busy_in_done", 32'(busy), 0);
            job_active = 1'b0;
        end else if (job_active && job_len != 0) begin
            chk("busy", 32'(busy), 1);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (fifo_rd_en) strobes++;
        rd_now = fifo_rd_en && !fifo_rd_error;
        rd_err = fifo_rd_en && fifo_rd_error;
        @(posedge clk);
        #1;
        if (rd_now) begin
            fifo_rd_data = fifo_q.pop_front();
            exp_q.push_back(fifo_rd_data);
            reads_ok++;
            chk("reads_within_len", 32'(reads_ok <= job_len), 1);
        end else begin
            fifo_rd_data = 8'($urandom);
        end
        if (rd_err) err_exp = 1'b1;
        if (rst_drv) begin
            exp_q.delete();
            delivered  = 0;
            err_exp    = 1'b0;
            job_active = 1'b0;
            prev_stall = 1'b0;
        end else if (start_drv && accept_drv) begin
            job_len    = int'(len_drv);
            delivered  = 0;
            reads_ok   = 0;
            strobes    = 0;
            done_cnt   = 0;
            err_exp    = 1'b0;
            job_active = 1'b1;
            got_q.delete();
        end
        chk("outstanding_le_2", 32'(exp_q.size() <= 2), 1);
    endtask

    task automatic start_job(input int l);
        start_drv  = 1'b1;
        accept_drv = 1'b1;
        len_drv    = CNT_WIDTH'(l);
        tick();
        start_drv  = 1'b0;
        accept_drv = 1'b0;
    endtask

    task automatic finish_job(input int l, output int cyc);
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        if (done_cnt == 0) chk("job_timeout", 32'(done_cnt), 1);
        tick();
        chk("one_done_pulse", 32'(done_cnt), 1);
        chk("words_delivered", 32'(delivered), 32'(l));
        chk("idle_after_done", 32'(busy), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_data"}, 32'(m_data), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rd_count"}, 32'(rd_count), 0);
    endtask

    task automatic set_source(input int total, input int pre, input int gap, input bit ramp);
        fifo_q.delete();
        src_q.delete();
        for (int i = 0; i < total; i++) begin
            logic [7:0] w;
            w = ramp ? 8'(2 * i) : 8'($urandom);
            if (i < pre) fifo_q.push_back(w);
            else         src_q.push_back(w);
        end
        push_gap = gap;
        gap_cnt  = 0;
    endtask

    vec_t tbl [8];

    initial begin
        int cyc;

        tbl[0] = '{1,  1,  0, 100, 0,  1,  1};
        tbl[1] = '{31, 31, 0, 100, 0,  31, 1};
        tbl[2] = '{12, 4,  1, 60,  0,  12, 1};
        tbl[3] = '{20, 0,  2, 40,  0,  20, 1};
        tbl[4] = '{15, 15, 0, 30,  20, 15, 1};
        tbl[5] = '{7,  3,  0, 90,  40, 7,  1};
        tbl[6] = '{2,  2,  0, 10,  0,  2,  1};
        tbl[7] = '{25, 10, 3, 75,  10, 25, 1};

        rst           = 1'b1;
        start         = 1'b0;
        len           = '0;
        m_ready       = 1'b0;
        fifo_rd_error = 1'b0;
        fifo_empty    = 1'b1;
        fifo_rd_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // Full drain of 0,2,...,30 at full rate
        set_source(16, 16, 0, 1'b1);
        ready_pct = 100;
        err_pct   = 0;
        start_job(16);
        finish_job(16, cyc);
        chk("drain_cycles", 32'(cyc), 20);
        chk("drain_strobes", 32'(strobes), 16);
        chk("drain_rd_count", 32'(rd_count), 16);
        chk("drain_got_size", 32'(got_q.size()), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            chk("drain_order", 32'(got_q[i]), 32'(2 * i));
        end

        // Backpressure: only two reads may be outstanding while the sink stalls
        set_source(16, 16, 0, 1'b1);
        ready_pct = 0;
        start_job(16);
        repeat (10) tick();
        chk("bp_strobes", 32'(strobes), 2);
        chk("bp_valid", 32'(m_valid), 1);
        chk("bp_data", 32'(m_data), 0);
        ready_pct = 100;
        finish_job(16, cyc);
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            chk("bp_order", 32'(got_q[i]), 32'(2 * i));
        end

        // Zero length: done the next cycle with no reads
        set_source(4, 4, 0, 1'b0);
        start_job(0);
        finish_job(0, cyc);
        chk("zero_done_latency", 32'(cyc), 1);
        chk("zero_strobes", 32'(strobes), 0);
        chk("zero_rd_count", 32'(rd_count), 0);

        // Starved FIFO: words arrive three cycles apart
        set_source(5, 0, 2, 1'b0);
        ready_pct = 100;
        start_job(5);
        finish_job(5, cyc);

        // Second start during a job is ignored
        set_source(12, 12, 0, 1'b0);
        ready_pct = 50;
        start_job(8);
        repeat (4) tick();
        start_drv = 1'b1;
        len_drv   = CNT_WIDTH'(2);
        tick();
        start_drv = 1'b0;
        finish_job(8, cyc);

        // Reset after three words delivered
        set_source(16, 16, 0, 1'b1);
        ready_pct = 100;
        start_job(16);
        cyc = 0;
        while (delivered < 3 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("mid_run_progress", 32'(delivered >= 3), 1);
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0;
        chk_reset_outputs("mid_reset");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_m_valid", 32'(m_valid), 0);
            chk("post_reset_rd_en", 32'(fifo_rd_en), 0);
            chk("post_reset_busy", 32'(busy), 0);
        end

        // Randomized jobs from the table
        for (int t = 0; t < 8; t++) begin
            set_source(tbl[t].len + 2, tbl[t].preload, tbl[t].push_gap, 1'b0);
            ready_pct = tbl[t].ready_pct;
            err_pct   = tbl[t].err_pct;
            start_job(tbl[t].len);
            finish_job(tbl[t].len, cyc);
            chk("tbl_words", 32'(delivered), 32'(tbl[t].exp_words));
            chk("tbl_done", 32'(done_cnt), 32'(tbl[t].exp_done));
            chk("tbl_rd_count", 32'(rd_count), 32'(tbl[t].exp_words));
        end
        err_pct = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width, equal to the FIFO data width.
REQ-002 SHALL have parameter CNT_WIDTH, default 5, meaning width of the length and count fields; 5 covers a 16-deep FIFO.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to drain len words.
REQ-006 SHALL have port len, input, CNT_WIDTH bits: word count, sampled on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: a drain job is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse on job completion.
REQ-009 SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-010 SHALL have port fifo_rd_en, output, 1 bit: FIFO read strobe.
REQ-011 SHALL have port fifo_rd_data, input, WIDTH bits: FIFO read data, valid one cycle after the strobe.
REQ-012 SHALL have port fifo_rd_error, input, 1 bit: FIFO underflow indication.
REQ-013 SHALL have port m_valid, output, 1 bit: output word available.
REQ-014 SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-015 SHALL have port m_data, output, WIDTH bits: output word.
REQ-016 SHALL have port err, output, 1 bit: sticky error flag.
REQ-017 SHALL have port rd_count, output, CNT_WIDTH bits: words delivered on m_* in the current job.

Function
REQ-018 SHALL implement the states IDLE, RUN and DONE; busy = (state==RUN).
REQ-019 SHALL accept start only in IDLE: latch len, clear rd_count, clear err, go to RUN; start in RUN or DONE is ignored.
REQ-020 SHALL, for start with len==0, go to DONE next cycle and issue no fifo_rd_en.
REQ-021 SHALL assert fifo_rd_en only when all hold: state==RUN, fifo_empty==0, issued<len, and (buffered + in-flight words) < 2.
REQ-022 SHALL capture fifo_rd_data into a 2-entry internal buffer on the cycle after a read strobe (read latency 1).
REQ-023 SHALL drive m_valid=1 whenever the buffer is non-empty, with m_data = the oldest buffered word.
REQ-024 SHALL count a transfer when m_valid && m_ready at a rising edge, pop the buffer and increment rd_count.
REQ-025 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-026 SHALL deliver words in FIFO order with no drop or duplication, including simultaneous capture and pop in the same cycle.
REQ-027 SHALL sustain one word per cycle when fifo_empty==0 and m_ready==1 continuously.
REQ-028 SHALL move from RUN to DONE when issued==len and rd_count==len; done=1 for exactly that cycle, then return to IDLE.
REQ-029 SHALL, on fifo_rd_error==1, set err=1, skip capture and issued increment for that read, and leave err held until reset or the next accepted start.
REQ-030 SHALL perform no count wrap within a job, given len <= 2^CNT_WIDTH-1.

Reset
REQ-031 SHALL, while rst=1 at a rising edge, enter IDLE with the buffer and issue counters cleared, and drive busy=0, done=0, fifo_rd_en=0, m_valid=0, m_data=0, err=0, rd_count=0.
REQ-032 SHALL, on reset during RUN, discard any in-flight read data arriving the cycle after reset and never present it on m_*.

Verification
REQ-033 SHALL cover a full drain: FIFO preloaded with 0,2,...,30, start len=16, m_ready=1 -> m_data 0,2,...,30 in order, rd_count=16, one done pulse, and fifo_rd_en never high while fifo_empty=1.
REQ-034 SHALL cover backpressure: 16 words preloaded, len=16, m_ready=0 for 10 cycles -> exactly 2 fifo_rd_en strobes, m_data=0 held stable, and the full sequence is delivered after m_ready=1.
REQ-035 SHALL cover zero length: start with len=0 -> done=1 on the next cycle, no fifo_rd_en, rd_count=0.
REQ-036 SHALL cover a starved FIFO: empty FIFO, start len=5, 5 words written 3 cycles apart -> busy stays 1, 5 words delivered, then done.
REQ-037 SHALL cover reset mid-run: rst=1 after 3 words delivered -> all outputs 0 next cycle, no m_valid and no fifo_rd_en until the next start.
REQ-038 SHALL cover start while busy: a second start with len=2 during a len=8 job -> ignored, exactly 8 words delivered, and one done pulse.
